miriscv_gpr_wb_arbiter: RTL and testbench

Shares the single GPR write port between the execute-stage (EX) and load/store-unit (LSU) writeback paths. After reset it runs an initialisation walk that zeroes x1..x(GPR_DEPTH-1). It then grants at most one writeback per cycle: LSU has priority, with an anti-starvation override for EX. It sits between the EX/LSU writeback outputs and the GPR file write port, and drives a registered write port with one cycle of latency.

---
 rtl/miriscv_gpr_pkg.sv | 13 +
 rtl/miriscv_gpr_wb_arbiter.sv | 107 ++++++++++
 tb/tb_miriscv_gpr_wb_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/miriscv_gpr_pkg.sv
// GPR file parameters and shared types for the register-file writeback path.
package miriscv_gpr_pkg;

    localparam bit RISCV_E        = 1'b0;
    localparam int GPR_DEPTH      = RISCV_E ? 16 : 32;
    localparam int GPR_ADDR_WIDTH = $clog2(GPR_DEPTH);

    typedef enum logic {
        INIT,
        ARB
    } gpr_wb_arb_state_e;

endpackage

// File: rtl/miriscv_gpr_wb_arbiter.sv
// GPR write-port arbiter: zeroes x1..xN after reset, then shares the port
// between EX and LSU writeback with LSU priority and an EX starvation override.
module miriscv_gpr_wb_arbiter
    import miriscv_gpr_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      ex_wb_valid_i,
    output logic                      ex_wb_ready_o,
    input  logic [GPR_ADDR_WIDTH-1:0] ex_wb_addr_i,
    input  logic [XLEN-1:0]           ex_wb_data_i,
    input  logic                      lsu_wb_valid_i,
    output logic                      lsu_wb_ready_o,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_wb_addr_i,
    input  logic [XLEN-1:0]           lsu_wb_data_i,
    output logic                      gpr_we_o,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr_o,
    output logic [XLEN-1:0]           gpr_wdata_o,
    output logic                      init_done_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [GPR_ADDR_WIDTH-1:0] INIT_LAST =
        GPR_ADDR_WIDTH'(GPR_DEPTH - 1);
    localparam logic [GPR_ADDR_WIDTH-1:0] INIT_FIRST =
        GPR_ADDR_WIDTH'(1);

    gpr_wb_arb_state_e         state_q;
    gpr_wb_arb_state_e         state_d;
    logic [GPR_ADDR_WIDTH-1:0] init_cnt_q;
    logic [3:0]                starve_q;
    logic                      override;
    logic                      ex_gnt;
    logic                      lsu_gnt;

    always_comb begin
        state_d  = state_q;
        ex_gnt   = 1'b0;
        lsu_gnt  = 1'b0;
        override = (starve_q == STARVE_MAX);
        unique case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                lsu_gnt = lsu_wb_valid_i && !override;
                ex_gnt  = ex_wb_valid_i && !lsu_gnt;
            end
            default: state_d = INIT;
        endcase
    end

    assign ex_wb_ready_o  = ex_gnt;
    assign lsu_wb_ready_o = lsu_gnt;
    assign init_done_o    = (state_q == ARB);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= INIT;
            init_cnt_q <= INIT_FIRST;
        end else begin
            state_q <= state_d;
            if (state_q == INIT && init_cnt_q != INIT_LAST) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

    // Counts lost EX cycles; the saturated value forces one EX transfer.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            starve_q <= '0;
        end else if (ex_gnt) begin
            starve_q <= '0;
        end else if (ex_wb_valid_i && starve_q != STARVE_MAX) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            gpr_we_o    <= 1'b0;
            gpr_waddr_o <= '0;
            gpr_wdata_o <= '0;
        end else if (state_q == INIT) begin
            gpr_we_o    <= 1'b1;
            gpr_waddr_o <= init_cnt_q;
            gpr_wdata_o <= '0;
        end else if (lsu_gnt) begin
            gpr_we_o    <= |lsu_wb_addr_i;
            gpr_waddr_o <= lsu_wb_addr_i;
            gpr_wdata_o <= lsu_wb_data_i;
        end else if (ex_gnt) begin
            gpr_we_o    <= |ex_wb_addr_i;
            gpr_waddr_o <= ex_wb_addr_i;
            gpr_wdata_o <= ex_wb_data_i;
        end else begin
            gpr_we_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_miriscv_gpr_wb_arbiter.sv
// Directed bench for the GPR writeback arbiter: init walk, priority,
// starvation override, x0 writes and asynchronous reset mid-walk.
module tb_miriscv_gpr_wb_arbiter;
    import miriscv_gpr_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      arstn_i = 1'b0;
    logic                      ex_wb_valid_i = 1'b0;
    logic                      ex_wb_ready_o;
    logic [GPR_ADDR_WIDTH-1:0] ex_wb_addr_i = '0;
    logic [31:0]               ex_wb_data_i = '0;
    logic                      lsu_wb_valid_i = 1'b0;
    logic                      lsu_wb_ready_o;
    logic [GPR_ADDR_WIDTH-1:0] lsu_wb_addr_i = '0;
    logic [31:0]               lsu_wb_data_i = '0;
    logic                      gpr_we_o;
    logic [GPR_ADDR_WIDTH-1:0] gpr_waddr_o;
    logic [31:0]               gpr_wdata_o;
    logic                      init_done_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    miriscv_gpr_wb_arbiter #(
        .XLEN         (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .ex_wb_valid_i  (ex_wb_valid_i),
        .ex_wb_ready_o  (ex_wb_ready_o),
        .ex_wb_addr_i   (ex_wb_addr_i),
        .ex_wb_data_i   (ex_wb_data_i),
        .lsu_wb_valid_i (lsu_wb_valid_i),
        .lsu_wb_ready_o (lsu_wb_ready_o),
        .lsu_wb_addr_i  (lsu_wb_addr_i),
        .lsu_wb_data_i  (lsu_wb_data_i),
        .gpr_we_o       (gpr_we_o),
        .gpr_waddr_o    (gpr_waddr_o),
        .gpr_wdata_o    (gpr_wdata_o),
        .init_done_o    (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we,
                          input int addr, input logic [31:0] data);
        chk({tag, " we"}, 64'(gpr_we_o), 64'(we));
        chk({tag, " addr"}, 64'(gpr_waddr_o), 64'(addr));
        chk({tag, " data"}, 64'(gpr_wdata_o), 64'(data));
    endtask

    task automatic walk(input string tag);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk_wr(tag, 1'b1, k, 32'h0);
            chk({tag, " done"}, 64'(init_done_o), 64'(k == 31));
            if (k < 31) begin
                chk({tag, " ex_rdy"}, 64'(ex_wb_ready_o), 64'd0);
                chk({tag, " lsu_rdy"}, 64'(lsu_wb_ready_o), 64'd0);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_wr(tag, 1'b0, 0, 32'h0);
        chk({tag, " done"}, 64'(init_done_o), 64'd0);
        chk({tag, " ex_rdy"}, 64'(ex_wb_ready_o), 64'd0);
        chk({tag, " lsu_rdy"}, 64'(lsu_wb_ready_o), 64'd0);
    endtask

    // LSU streams continuously; EX must win on the fifth cycle.
    task automatic starve_run(input string tag, input int ex_a,
                              input logic [31:0] ex_d, input int base);
        ex_wb_valid_i  = 1'b1;
        ex_wb_addr_i   = GPR_ADDR_WIDTH'(ex_a);
        ex_wb_data_i   = ex_d;
        lsu_wb_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_wb_addr_i = GPR_ADDR_WIDTH'(base + i);
            lsu_wb_data_i = 32'h100 + 32'(i);
            #1;
            chk({tag, " lsu_rdy"}, 64'(lsu_wb_ready_o), 64'd1);
            chk({tag, " ex_rdy"}, 64'(ex_wb_ready_o), 64'd0);
            tick();
            chk_wr({tag, " lsu_wr"}, 1'b1, base + i, 32'h100 + 32'(i));
        end
        lsu_wb_addr_i = GPR_ADDR_WIDTH'(base + 4);
        lsu_wb_data_i = 32'h104;
        #1;
        chk({tag, " ovr ex_rdy"}, 64'(ex_wb_ready_o), 64'd1);
        chk({tag, " ovr lsu_rdy"}, 64'(lsu_wb_ready_o), 64'd0);
        tick();
        chk_wr({tag, " ex_wr"}, 1'b1, ex_a, ex_d);
        ex_wb_valid_i = 1'b0;
        #1;
        chk({tag, " resume"}, 64'(lsu_wb_ready_o), 64'd1);
        tick();
        chk_wr({tag, " resume_wr"}, 1'b1, base + 4, 32'h104);
        lsu_wb_valid_i = 1'b0;
    endtask

    initial begin
        #1;
        chk_zero("reset");
        @(negedge clk_i);
        arstn_i = 1'b1;
        walk("init");
        tick();
        chk_wr("idle", 1'b0, 31, 32'h0);

        ex_wb_valid_i  = 1'b1;
        ex_wb_addr_i   = 5'd5;
        ex_wb_data_i   = 32'h11;
        lsu_wb_valid_i = 1'b1;
        lsu_wb_addr_i  = 5'd6;
        lsu_wb_data_i  = 32'h22;
        #1;
        chk("sim lsu_rdy", 64'(lsu_wb_ready_o), 64'd1);
        chk("sim ex_rdy", 64'(ex_wb_ready_o), 64'd0);
        tick();
        chk_wr("sim x6", 1'b1, 6, 32'h22);
        lsu_wb_valid_i = 1'b0;
        #1;
        chk("sim ex_rdy2", 64'(ex_wb_ready_o), 64'd1);
        tick();
        chk_wr("sim x5", 1'b1, 5, 32'h11);
        ex_wb_valid_i = 1'b0;
        tick();
        chk_wr("sim idle", 1'b0, 5, 32'h11);

        starve_run("starve", 7, 32'hAA, 8);

        ex_wb_valid_i  = 1'b1;
        ex_wb_addr_i   = 5'd0;
        ex_wb_data_i   = 32'hDEAD;
        lsu_wb_valid_i = 1'b1;
        lsu_wb_addr_i  = 5'd10;
        lsu_wb_data_i  = 32'h10;
        #1;
        chk("x0 lsu_rdy", 64'(lsu_wb_ready_o), 64'd1);
        tick();
        chk_wr("x0 lsu_wr", 1'b1, 10, 32'h10);
        lsu_wb_valid_i = 1'b0;
        #1;
        chk("x0 ex_rdy", 64'(ex_wb_ready_o), 64'd1);
        tick();
        chk_wr("x0 wr", 1'b0, 0, 32'hDEAD);
        ex_wb_valid_i = 1'b0;
        starve_run("x0 clr", 11, 32'hB1, 12);

        arstn_i = 1'b0;
        #1;
        chk_zero("reset2");
        @(negedge clk_i);
        arstn_i        = 1'b1;
        lsu_wb_valid_i = 1'b1;
        lsu_wb_addr_i  = 5'd9;
        lsu_wb_data_i  = 32'h99;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk_wr("half walk", 1'b1, k, 32'h0);
        end
        #2;
        arstn_i = 1'b0;
        lsu_wb_valid_i = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk_i);
        arstn_i = 1'b1;
        walk("rewalk");
        tick();
        chk_wr("no pend", 1'b0, 31, 32'h0);
        tick();
        chk_wr("no pend2", 1'b0, 31, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
